led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
Autonomous LED matrix scan engine, parametrised in line count and column width. The CPU loads a frame buffer once through memory-mapped ports. The block then scans lines in hardware with a programmable line period and anti-ghosting dead time, and raises a frame-done pulse at each wrap. It sits on the CPU I/O port bus beside the input-switch block and drives the external LED board directly.

Parameters:
LINES, 20, number of scan lines (2..32)
COLS, 10, LED columns per line (1..DATA_W)
DATA_W, 32, CPU data bus width
ADDR_W, 4, local port address width
DEAD_CYC, 4, blanking clocks between lines (1..255)

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous, active-low reset
iAddr  in  ADDR_W  local port address
iData  in  DATA_W  CPU write data
iWEnb  in  1  port write strobe, one clock per write
oData  out  DATA_W  read data for iAddr, combinational
oLED_Data  out  COLS  column data for the active line, 1 = on
oLED_LineSel  out  LINES  line select, active-low one-hot
oFrameDone  out  1  one-clock pulse when the last line's drive period ends

Behaviour:
- Reset is asynchronous on iRst_n low. State goes to IDLE.
- Reset values: oLED_LineSel = all ones, oLED_Data = 0, oFrameDone = 0, CTRL = 0, PTR = 0, DIV = 0, all frame-buffer lines = 0, scan line = 0, frame count = 0.
- Port map, write:
  - 0 CTRL: bit0 EN (scan enable), bit1 BLANK (force outputs off while keeping scan timing).
  - 1 PTR: frame-buffer write pointer. A value >= LINES loads 0.
  - 2 LDATA: writes iData[COLS-1:0] to line PTR, then PTR increments. PTR wraps from LINES-1 to 0.
  - 3 DIV: iData[15:0] sets the drive period to DIV+1 clocks. Writing DIV restarts the period counter.
- Port map, read: 0 CTRL, 1 PTR, 2 frame buffer[PTR], 3 DIV, 4 STATUS ({frame count[15:0], scan line[4:0]} packed at bits [20:0]). All other addresses read 0.
- States: IDLE, DEAD, DRIVE.
- IDLE: outputs off. When EN = 1, go to DEAD with scan line = 0 and the counter loaded with DEAD_CYC-1.
- DEAD:
  - LineSel = all ones and Data = 0.
  - When the counter reaches 0, latch the frame buffer for the current scan line into a shadow register, load the counter with DIV, and go to DRIVE.
- DRIVE:
  - LineSel bit[scan line] = 0 and Data = shadow register. If BLANK = 1, LineSel = all ones and Data = 0.
  - When the counter reaches 0: go to DEAD and advance the scan line, wrapping from LINES-1 to 0.
  - At that wrap, oFrameDone pulses for one clock and frame count increments, wrapping at 16 bits.
- Outputs are registered. Each line drives for DIV+1 clocks and blanks for DEAD_CYC clocks, so one frame = LINES*(DIV+1+DEAD_CYC) clocks.
- Writing EN = 0 in any state forces IDLE on the next clock, with outputs off the same edge. Scan line and frame count are held. Re-enabling restarts from line 0.
- LDATA to the line currently in DRIVE does not change the displayed data until that line's next DRIVE entry, because of the shadow latch.
- A DIV write during DRIVE reloads the counter with the new DIV, extending the current line. A DIV write in DEAD takes effect at the next DRIVE entry.
- LDATA and PTR writes are single-cycle, one per iWEnb. No write has any side effect when iWEnb = 0.

Decomposition:
- Shared package holds:
  - port offsets (PORT_CTRL = 0, PORT_PTR = 1, PORT_LDATA = 2, PORT_DIV = 3, PORT_STATUS = 4)
  - CTRL bit indices (CTRL_EN = 0, CTRL_BLANK = 1)
  - the 2-bit state encoding (IDLE = 0, DEAD = 1, DRIVE = 2)
- One sub-module, led_line_decoder: parametrised LINES, maps line index plus an enable to the active-low one-hot select. It outputs all ones when the enable is low or the index is >= LINES.

Test Plan:
- Reset with iRst_n = 0 mid-DRIVE, asynchronously -> LineSel = 20'hFFFFF and Data = 0 immediately; STATUS reads 0 after release.
- PTR = 0; LDATA 0x001..0x014 (20 writes); 21st LDATA of 0x3FF -> line 0 = 0x3FF, PTR reads 1, line 19 = 0x014.
- DIV = 9, EN = 1 -> line 0 drives 0x3FF for 10 clocks after a 4-clock DEAD; a full frame = 280 clocks; oFrameDone pulses once per 280 clocks; frame count increments.
- During line 5 DRIVE, LDATA line 5 = 0x155 -> current drive unchanged; next frame's line 5 shows 0x155.
- CTRL = 3 (EN + BLANK) -> LineSel stays 20'hFFFFF; scan line and oFrameDone still advance with the same period.
- EN = 0 mid-line 7 -> next clock IDLE, outputs off, STATUS scan line = 7; EN = 1 -> scan restarts at line 0 after DEAD.

Source files
------------

// File: rtl/led_matrix_scanner_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_scanner_pkg
// Shared constants for the LED matrix scan engine:
//   - local port offsets of the CPU register window
//   - CTRL register bit positions
//   - scan FSM state encoding
//   - width of line indices (scan line and frame-buffer pointer)
// ---------------------------------------------------------------------------
package led_matrix_scanner_pkg;

  localparam int unsigned PORT_CTRL   = 0;
  localparam int unsigned PORT_PTR    = 1;
  localparam int unsigned PORT_LDATA  = 2;
  localparam int unsigned PORT_DIV    = 3;
  localparam int unsigned PORT_STATUS = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLANK = 1;

  // Line indices are always 5 bits so up to 32 lines fit and STATUS
  // packing stays fixed regardless of LINES.
  localparam int LINE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/led_matrix_scanner_line_decoder.sv
// ---------------------------------------------------------------------------
// led_line_decoder
// Converts a line index into an active-low one-hot line select.
//   line_i   : line index
//   en_i     : 1 = drive the selected line, 0 = all lines off
//   sel_n_o  : active-low one-hot select; all ones when disabled or when
//              line_i is outside 0..LINES-1
// ---------------------------------------------------------------------------
module led_line_decoder
  import led_matrix_scanner_pkg::*;
#(
  parameter int LINES = 20
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic              en_i,
  output logic [LINES-1:0]  sel_n_o
);

  always_comb begin
    sel_n_o = '1;
    if (en_i && (32'(line_i) < LINES)) begin
      sel_n_o[line_i] = 1'b0;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// ---------------------------------------------------------------------------
// led_matrix_scanner
// Autonomous LED matrix scan engine. The CPU fills a frame buffer through a
// small port window; the block then scans lines on its own, separating each
// line's drive period (DIV+1 clocks) with DEAD_CYC blanking clocks.
//
// Ports:
//   iClk, iRst_n  : clock, asynchronous active-low reset
//   iAddr, iData  : CPU port address / write data
//   iWEnb         : one-clock write strobe
//   oData         : combinational read data for iAddr
//   oLED_Data     : registered column data of the active line (1 = on)
//   oLED_LineSel  : registered active-low one-hot line select
//   oFrameDone    : registered one-clock pulse when the last line's drive ends
//
// Register window (write / read):
//   0 CTRL   bit0 EN, bit1 BLANK
//   1 PTR    frame-buffer pointer (values >= LINES load 0)
//   2 LDATA  write line[PTR] then PTR++ (wraps) / read line[PTR]
//   3 DIV    drive period minus one
//   4 STATUS read only: {frame count[15:0], scan line[4:0]}
//
// Handshake: a write is accepted on every clock where iWEnb = 1; there is
// no back-pressure and reads are purely combinational on iAddr.
// ---------------------------------------------------------------------------
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int LINES    = 20,
  parameter int COLS     = 10,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int DEAD_CYC = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iWEnb,
  output logic [DATA_W-1:0] oData,
  output logic [COLS-1:0]   oLED_Data,
  output logic [LINES-1:0]  oLED_LineSel,
  output logic              oFrameDone
);

  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(LINES - 1);
  localparam logic [15:0]       DEAD_RELOAD = 16'(DEAD_CYC - 1);

  // Register file
  logic [1:0]        ctrl_q, ctrl_d;
  logic [LINE_W-1:0] ptr_q, ptr_d;
  logic [15:0]       div_q, div_d;
  logic [COLS-1:0]   fb_q [LINES];

  // Scan engine
  scan_state_e       state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [COLS-1:0]   shadow_q, shadow_d;
  logic              wrap;

  // Registered outputs
  logic [COLS-1:0]   led_data_q, led_data_d;
  logic [LINES-1:0]  sel_n_q, sel_n_d;
  logic              fdone_q, fdone_d;

  logic wr_ctrl, wr_ptr, wr_ldata, wr_div;
  logic en_d, blank_d, drive_on;

  // -------------------------------------------------------------------------
  // Port decode and register next values
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ctrl  = iWEnb && (iAddr == ADDR_W'(PORT_CTRL));
    wr_ptr   = iWEnb && (iAddr == ADDR_W'(PORT_PTR));
    wr_ldata = iWEnb && (iAddr == ADDR_W'(PORT_LDATA));
    wr_div   = iWEnb && (iAddr == ADDR_W'(PORT_DIV));

    ctrl_d = wr_ctrl ? iData[1:0] : ctrl_q;
    div_d  = wr_div ? iData[15:0] : div_q;

    ptr_d = ptr_q;
    if (wr_ptr) begin
      ptr_d = (iData < DATA_W'(LINES)) ? iData[LINE_W-1:0] : '0;
    end else if (wr_ldata) begin
      ptr_d = (ptr_q == LAST_LINE) ? '0 : ptr_q + 1'b1;
    end

    // A CTRL write acts on the same edge it is captured, so EN = 0 turns
    // the outputs off without an extra clock of latency.
    en_d    = ctrl_d[CTRL_EN];
    blank_d = ctrl_d[CTRL_BLANK];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ctrl_q <= '0;
      ptr_q  <= '0;
      div_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        fb_q[i] <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      ptr_q  <= ptr_d;
      div_q  <= div_d;
      if (wr_ldata) begin
        fb_q[ptr_q] <= iData[COLS-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      fcnt_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      fcnt_q   <= fcnt_d;
      shadow_q <= shadow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    fcnt_d   = fcnt_q;
    shadow_d = shadow_q;
    wrap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_d) begin
          state_d = ST_DEAD;
          line_d  = '0;
          cnt_d   = DEAD_RELOAD;
        end
      end
      ST_DEAD: begin
        if (cnt_q == '0) begin
          // Snapshot the line so CPU writes cannot tear the active drive.
          shadow_d = fb_q[line_q];
          cnt_d    = div_d;
          state_d  = ST_DRIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRIVE: begin
        if (wr_div) begin
          // Restart the period with the new value, stretching this line.
          cnt_d = div_d;
        end else if (cnt_q == '0) begin
          state_d = ST_DEAD;
          cnt_d   = DEAD_RELOAD;
          if (line_q == LAST_LINE) begin
            line_d = '0;
            fcnt_d = fcnt_q + 1'b1;
            wrap   = 1'b1;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disabling wins over everything; scan position and frame count hold.
    if (!en_d) begin
      state_d  = ST_IDLE;
      line_d   = line_q;
      fcnt_d   = fcnt_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      wrap     = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: outputs (computed from next state, then registered)
  // -------------------------------------------------------------------------
  led_line_decoder #(
    .LINES (LINES)
  ) u_line_decoder (
    .line_i  (line_d),
    .en_i    (drive_on),
    .sel_n_o (sel_n_d)
  );

  always_comb begin
    drive_on   = (state_d == ST_DRIVE) && !blank_d;
    led_data_d = drive_on ? shadow_d : '0;
    fdone_d    = wrap;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      led_data_q <= '0;
      sel_n_q    <= '1;
      fdone_q    <= 1'b0;
    end else begin
      led_data_q <= led_data_d;
      sel_n_q    <= sel_n_d;
      fdone_q    <= fdone_d;
    end
  end

  assign oLED_Data    = led_data_q;
  assign oLED_LineSel = sel_n_q;
  assign oFrameDone   = fdone_q;

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    oData = '0;
    case (iAddr)
      ADDR_W'(PORT_CTRL):   oData = DATA_W'(ctrl_q);
      ADDR_W'(PORT_PTR):    oData = DATA_W'(ptr_q);
      ADDR_W'(PORT_LDATA):  oData = DATA_W'(fb_q[ptr_q]);
      ADDR_W'(PORT_DIV):    oData = DATA_W'(div_q);
      ADDR_W'(PORT_STATUS): oData = DATA_W'({fcnt_q, line_q});
      default:              oData = '0;
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scanner
// Directed bench for led_matrix_scanner with hand-computed expectations.
// Time base: inputs change and outputs are sampled on the falling edge;
// cycle c of a scan counts falling edges after the EN write edge.
// ---------------------------------------------------------------------------
module tb_led_matrix_scanner;

  localparam int LINES    = 20;
  localparam int COLS     = 10;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int DEAD_CYC = 4;

  logic              iClk;
  logic              iRst_n;
  logic [ADDR_W-1:0] iAddr;
  logic [DATA_W-1:0] iData;
  logic              iWEnb;
  logic [DATA_W-1:0] oData;
  logic [COLS-1:0]   oLED_Data;
  logic [LINES-1:0]  oLED_LineSel;
  logic              oFrameDone;

  int vectors;
  int miscompares;

  led_matrix_scanner #(
    .LINES    (LINES),
    .COLS     (COLS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iAddr        (iAddr),
    .iData        (iData),
    .iWEnb        (iWEnb),
    .oData        (oData),
    .oLED_Data    (oLED_Data),
    .oLED_LineSel (oLED_LineSel),
    .oFrameDone   (oFrameDone)
  );

  // Clock / watchdog
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // -------------------------------------------------------------------------
  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    iAddr = a;
    iData = d;
    iWEnb = 1'b1;
    @(negedge iClk);
    iWEnb = 1'b0;
    iData = '0;
  endtask

  task automatic read_reg(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    iAddr = a;
    #1;
    d = oData;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [DATA_W-1:0] rd;
    iRst_n = 1'b0;
    iAddr  = '0;
    iData  = '0;
    iWEnb  = 1'b0;
    wait_cyc(3);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF || oLED_Data !== 10'h000 || oFrameDone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: sel=%h data=%h fd=%b, want sel=fffff data=000 fd=0",
               oLED_LineSel, oLED_Data, oFrameDone);
    end
    iRst_n = 1'b1;
    wait_cyc(1);
    for (int a = 0; a < 5; a++) begin
      read_reg(ADDR_W'(a), rd);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h want 00000000", a, rd);
      end
    end
  endtask

  task automatic test_load();
    logic [DATA_W-1:0] rd;
    // A strobe-less cycle on LDATA must leave PTR and the buffer alone.
    iAddr = 4'd2;
    iData = 32'h3AA;
    wait_cyc(1);
    read_reg(4'd1, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL no_wenb_ptr: got %0d want 0", rd);
    end
    write_reg(4'd1, 32'd0);
    for (int i = 1; i <= 20; i++) write_reg(4'd2, 32'(i));
    write_reg(4'd2, 32'h3FF);
    read_reg(4'd1, rd);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++;
      $display("FAIL ptr_wrap: got %0d want 1", rd);
    end
    read_reg(4'd2, rd);
    vectors++;
    if (rd !== 32'h002) begin
      miscompares++;
      $display("FAIL line1_read: got %h want 002", rd);
    end
    write_reg(4'd1, 32'd0);
    read_reg(4'd2, rd);
    vectors++;
    if (rd !== 32'h3FF) begin
      miscompares++;
      $display("FAIL line0_read: got %h want 3ff", rd);
    end
    write_reg(4'd1, 32'd19);
    read_reg(4'd2, rd);
    vectors++;
    if (rd !== 32'h014) begin
      miscompares++;
      $display("FAIL line19_read: got %h want 014", rd);
    end
    write_reg(4'd1, 32'd25);
    read_reg(4'd1, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL ptr_oob: got %0d want 0", rd);
    end
    read_reg(4'd7, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h want 0", rd);
    end
  endtask

  task automatic test_scan();
    logic [DATA_W-1:0] rd;
    int first_on, on0, fd_n, fd1, fd2;
    logic [LINES-1:0] l1_sel, l19_sel;
    logic [COLS-1:0]  l1_dat, l19_dat;
    first_on = -1; on0 = 0; fd_n = 0; fd1 = -1; fd2 = -1;
    l1_sel = '0; l19_sel = '0; l1_dat = '0; l19_dat = '0;
    write_reg(4'd3, 32'd9);
    write_reg(4'd0, 32'd1);
    for (int c = 1; c <= 570; c++) begin
      @(negedge iClk);
      if (oLED_LineSel !== 20'hFFFFF && first_on < 0) first_on = c;
      if (c < 14 && oLED_LineSel === 20'hFFFFE && oLED_Data === 10'h3FF) on0++;
      if (oFrameDone === 1'b1) begin
        fd_n++;
        if (fd_n == 1) fd1 = c;
        if (fd_n == 2) fd2 = c;
      end
      if (c == 18)  begin l1_sel  = oLED_LineSel; l1_dat  = oLED_Data; end
      if (c == 270) begin l19_sel = oLED_LineSel; l19_dat = oLED_Data; end
    end
    vectors++;
    if (first_on !== 4) begin
      miscompares++;
      $display("FAIL dead_before_line0: first drive at cycle %0d want 4", first_on);
    end
    vectors++;
    if (on0 !== 10) begin
      miscompares++;
      $display("FAIL line0_drive_len: %0d cycles want 10", on0);
    end
    vectors++;
    if (l1_sel !== 20'hFFFFD || l1_dat !== 10'h002) begin
      miscompares++;
      $display("FAIL line1_drive: sel=%h data=%h want fffffd/002", l1_sel, l1_dat);
    end
    vectors++;
    if (l19_sel !== 20'h7FFFF || l19_dat !== 10'h014) begin
      miscompares++;
      $display("FAIL line19_drive: sel=%h data=%h want 7ffff/014", l19_sel, l19_dat);
    end
    vectors++;
    if (fd_n !== 2 || fd1 !== 280 || fd2 !== 560) begin
      miscompares++;
      $display("FAIL frame_done: count=%0d at %0d,%0d want 2 at 280,560", fd_n, fd1, fd2);
    end
    read_reg(4'd4, rd);
    vectors++;
    if (rd !== 32'h40) begin
      miscompares++;
      $display("FAIL status_after_frames: got %h want 00000040", rd);
    end
    write_reg(4'd0, 32'd0);
  endtask

  task automatic test_shadow();
    write_reg(4'd1, 32'd5);
    write_reg(4'd0, 32'd1);
    wait_cyc(76);
    write_reg(4'd2, 32'h155);
    vectors++;
    if (oLED_LineSel !== 20'hFFFDF || oLED_Data !== 10'h006) begin
      miscompares++;
      $display("FAIL shadow_hold: sel=%h data=%h want fffdf/006", oLED_LineSel, oLED_Data);
    end
    wait_cyc(6);
    vectors++;
    if (oLED_LineSel !== 20'hFFFDF || oLED_Data !== 10'h006) begin
      miscompares++;
      $display("FAIL shadow_last: sel=%h data=%h want fffdf/006", oLED_LineSel, oLED_Data);
    end
    wait_cyc(1);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF || oLED_Data !== 10'h000) begin
      miscompares++;
      $display("FAIL line5_end: sel=%h data=%h want fffff/000", oLED_LineSel, oLED_Data);
    end
    wait_cyc(270);
    vectors++;
    if (oLED_LineSel !== 20'hFFFDF || oLED_Data !== 10'h155) begin
      miscompares++;
      $display("FAIL shadow_next_frame: sel=%h data=%h want fffdf/155", oLED_LineSel, oLED_Data);
    end
    write_reg(4'd0, 32'd0);
  endtask

  task automatic test_blank();
    logic [DATA_W-1:0] rd;
    int lit, fd1;
    lit = 0; fd1 = -1;
    rd  = '0;
    write_reg(4'd0, 32'd3);
    for (int c = 1; c <= 300; c++) begin
      @(negedge iClk);
      if (oLED_LineSel !== 20'hFFFFF || oLED_Data !== 10'h000) lit++;
      if (oFrameDone === 1'b1 && fd1 < 0) fd1 = c;
      if (c == 100) read_reg(4'd4, rd);
    end
    vectors++;
    if (lit !== 0) begin
      miscompares++;
      $display("FAIL blank_outputs: %0d lit cycles want 0", lit);
    end
    vectors++;
    if (rd !== 32'h67) begin
      miscompares++;
      $display("FAIL blank_status: got %h want 00000067", rd);
    end
    vectors++;
    if (fd1 !== 280) begin
      miscompares++;
      $display("FAIL blank_frame_done: at %0d want 280", fd1);
    end
    write_reg(4'd0, 32'd0);
  endtask

  task automatic test_disable();
    logic [DATA_W-1:0] rd;
    write_reg(4'd0, 32'd1);
    wait_cyc(105);
    vectors++;
    if (oLED_LineSel !== 20'hFFF7F) begin
      miscompares++;
      $display("FAIL line7_drive: sel=%h want fff7f", oLED_LineSel);
    end
    write_reg(4'd0, 32'd0);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF || oLED_Data !== 10'h000) begin
      miscompares++;
      $display("FAIL disable_off: sel=%h data=%h want fffff/000", oLED_LineSel, oLED_Data);
    end
    read_reg(4'd4, rd);
    vectors++;
    if (rd !== 32'h87) begin
      miscompares++;
      $display("FAIL disable_status: got %h want 00000087", rd);
    end
    wait_cyc(4);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF) begin
      miscompares++;
      $display("FAIL idle_stays_off: sel=%h want fffff", oLED_LineSel);
    end
    write_reg(4'd0, 32'd1);
    read_reg(4'd4, rd);
    vectors++;
    if (rd !== 32'h80) begin
      miscompares++;
      $display("FAIL restart_line0: got %h want 00000080", rd);
    end
    wait_cyc(3);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF) begin
      miscompares++;
      $display("FAIL restart_dead: sel=%h want fffff", oLED_LineSel);
    end
    wait_cyc(1);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFE || oLED_Data !== 10'h3FF) begin
      miscompares++;
      $display("FAIL restart_drive: sel=%h data=%h want ffffe/3ff", oLED_LineSel, oLED_Data);
    end
  endtask

  // Continues the scan started by test_disable (line 0 driving, cycle 4).
  task automatic test_div_extend();
    write_reg(4'd3, 32'd19);
    wait_cyc(9);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFE) begin
      miscompares++;
      $display("FAIL div_extend_c14: sel=%h want ffffe", oLED_LineSel);
    end
    wait_cyc(10);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFE) begin
      miscompares++;
      $display("FAIL div_extend_c24: sel=%h want ffffe", oLED_LineSel);
    end
    wait_cyc(1);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF) begin
      miscompares++;
      $display("FAIL div_extend_end: sel=%h want fffff", oLED_LineSel);
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] rd;
    wait_cyc(6);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFD || oLED_Data !== 10'h002) begin
      miscompares++;
      $display("FAIL pre_reset_drive: sel=%h data=%h want ffffd/002", oLED_LineSel, oLED_Data);
    end
    #2;
    iRst_n = 1'b0;
    #1;
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF || oLED_Data !== 10'h000 || oFrameDone !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: sel=%h data=%h fd=%b want fffff/000/0",
               oLED_LineSel, oLED_Data, oFrameDone);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    read_reg(4'd4, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL status_after_reset: got %h want 0", rd);
    end
    read_reg(4'd3, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL div_after_reset: got %h want 0", rd);
    end
    read_reg(4'd2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL fb_after_reset: got %h want 0", rd);
    end
    wait_cyc(3);
    vectors++;
    if (oLED_LineSel !== 20'hFFFFF) begin
      miscompares++;
      $display("FAIL idle_after_reset: sel=%h want fffff", oLED_LineSel);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    iRst_n = 1'b0;
    iAddr  = '0;
    iData  = '0;
    iWEnb  = 1'b0;
    @(negedge iClk);
    test_reset();
    test_load();
    test_scan();
    test_shadow();
    test_blank();
    test_disable();
    test_div_extend();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
